// File: rtl/snake_pkg.sv
// Shared types for the snake game: direction codes, grid defaults, cells.
// Optional build macro WRAP_EN (edge wrap-around) is consumed by snake_body_ctrl.
package snake_pkg;

  localparam int XW         = 8;
  localparam int YW         = 7;
  localparam int GRID_W_DEF = 160;
  localparam int GRID_H_DEF = 120;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DEAD
  } state_e;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } cell_t;

endpackage

// File: rtl/snake_tick_gen.sv
// Move-rate prescaler: counts enabled cycles, pulses TICK on the last one.
// CLR forces the count back to zero and suppresses the pulse.
module snake_tick_gen #(
  parameter int unsigned TICK_DIV = 10_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    TICK  = 1'b0;
    if (CLR) begin
      cnt_d = '0;
    end else if (EN) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        TICK  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake head/body controller with growth, collision and per-cell query.
// Build macro WRAP_EN: grid edges wrap instead of killing the snake.
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 4,
  parameter int TICK_DIV = 10_000_000,
  parameter int START_X  = 80,
  parameter int START_Y  = 60
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ENABLE,
  input  logic [1:0]    DIRECTION,
  input  logic          GROW,
  input  logic [XW-1:0] QUERY_X,
  input  logic [YW-1:0] QUERY_Y,
  output logic          SNAKE_HIT,
  output logic [XW-1:0] HEAD_X,
  output logic [YW-1:0] HEAD_Y,
  output logic [5:0]    LENGTH,
  output logic          MOVE_TICK,
  output logic          GAME_OVER
);

  localparam int LW = 6;

  state_e        state_q, state_d;
  cell_t         seg_q [MAX_LEN];
  cell_t         seg_d [MAX_LEN];
  logic [LW-1:0] length_q, length_d;
  logic          grow_q, grow_d;
  logic          move_tick_q, move_tick_d;
  logic          snake_hit_q, snake_hit_d;

  logic          tick;
  cell_t         nh;
  logic          at_edge, wall, self_hit, grow_now;
  logic [LW-1:0] lim;

  snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (state_q == ST_RUN && ENABLE),
    .CLR   (state_q == ST_IDLE),
    .TICK  (tick)
  );

  always_comb begin
    nh      = seg_q[0];
    at_edge = 1'b0;
    unique case (DIRECTION)
      DIR_UP: begin
        at_edge = seg_q[0].y == '0;
        nh.y = at_edge ? YW'(GRID_H - 1) : seg_q[0].y - 1'b1;
      end
      DIR_DOWN: begin
        at_edge = seg_q[0].y == YW'(GRID_H - 1);
        nh.y = at_edge ? '0 : seg_q[0].y + 1'b1;
      end
      DIR_LEFT: begin
        at_edge = seg_q[0].x == '0;
        nh.x = at_edge ? XW'(GRID_W - 1) : seg_q[0].x - 1'b1;
      end
      DIR_RIGHT: begin
        at_edge = seg_q[0].x == XW'(GRID_W - 1);
        nh.x = at_edge ? '0 : seg_q[0].x + 1'b1;
      end
    endcase
`ifdef WRAP_EN
    wall = 1'b0;
`else
    wall = at_edge;
`endif
  end

  // When not growing, the tail cell is vacated by this move and is legal.
  always_comb begin
    grow_now = (grow_q | GROW) && (length_q < LW'(MAX_LEN));
    lim      = grow_now ? length_q : length_q - 1'b1;
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < lim && seg_q[i] == nh) self_hit = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    length_d    = length_q;
    grow_d      = grow_q;
    move_tick_d = 1'b0;
    snake_hit_d = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) < length_q && seg_q[i] == {QUERY_X, QUERY_Y})
        snake_hit_d = 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        grow_d = grow_q | GROW;
        if (ENABLE) state_d = ST_RUN;
      end
      ST_RUN: begin
        grow_d = grow_q | GROW;
        if (tick) begin
          if (wall || self_hit) begin
            state_d = ST_DEAD;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) seg_d[i] = seg_q[i-1];
            seg_d[0]    = nh;
            length_d    = length_q + LW'(grow_now);
            grow_d      = 1'b0;
            move_tick_d = 1'b1;
          end
        end
      end
      ST_DEAD: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      length_q    <= LW'(INIT_LEN);
      grow_q      <= 1'b0;
      move_tick_q <= 1'b0;
      snake_hit_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_q[i].x <= XW'(START_X - i);
        seg_q[i].y <= YW'(START_Y);
      end
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      length_q    <= length_d;
      grow_q      <= grow_d;
      move_tick_q <= move_tick_d;
      snake_hit_q <= snake_hit_d;
    end
  end

  assign SNAKE_HIT = snake_hit_q;
  assign HEAD_X    = seg_q[0].x;
  assign HEAD_Y    = seg_q[0].y;
  assign LENGTH    = length_q;
  assign MOVE_TICK = move_tick_q;
  assign GAME_OVER = (state_q == ST_DEAD);

endmodule

// File: doc/snake_body_ctrl.md
# snake_body_ctrl

Snake body controller; sits directly downstream of the direction navigation state machine. Consumes its 2-bit direction code, advances the snake head one grid cell per move tick, and shifts the body segment buffer behind it. Handles growth on target capture and detects self/wall collision. Answers registered per-cell "is snake" queries for the VGA colour stage.

## Interface
- GRID_W, 160, grid width in cells (X range 0..GRID_W-1)
- GRID_H, 120, grid height in cells (Y range 0..GRID_H-1)
- MAX_LEN, 32, segment buffer depth (maximum snake length)
- INIT_LEN, 4, length after reset (2..MAX_LEN)
- TICK_DIV, 10_000_000, CLK cycles per move
- START_X, 80 / START_Y, 60, head position after reset
- CLK  in  1  system clock
- RESET  in  1  reset, synchronous, active-high
- ENABLE  in  1  game running; low pauses movement
- DIRECTION  in  2  0 UP, 1 RIGHT, 2 DOWN, 3 LEFT
- GROW  in  1  one-cycle pulse: target eaten
- QUERY_X  in  8  cell X to test
- QUERY_Y  in  7  cell Y to test
- SNAKE_HIT  out  1  queried cell holds an active segment (registered)
- HEAD_X  out  8  / HEAD_Y  out  7  current head cell
- LENGTH  out  6  active segment count
- MOVE_TICK  out  1  one-cycle pulse on every committed move
- GAME_OVER  out  1  sticky collision flag

## Operation
- States: IDLE, RUN, DEAD. Reset -> IDLE.
- IDLE: ENABLE=1 -> RUN, tick counter cleared to 0.
- RUN: counter increments while ENABLE=1 and holds while ENABLE=0. On count TICK_DIV-1, counter wraps to 0 and a move is evaluated; DIRECTION is sampled in that cycle.
- Next head: UP Y-1, DOWN Y+1, LEFT X-1, RIGHT X+1.
- Grow: GROW sets grow_pending (any state except DEAD). A move with grow_pending and LENGTH<MAX_LEN gives LENGTH+1 and clears grow_pending. At MAX_LEN, grow_pending clears and LENGTH holds.
- Self-collision: compare next head with old segments 0..LENGTH-2, or 0..LENGTH-1 when growing. The tail cell vacated this move is legal.
- Collision -> DEAD. No shift, no MOVE_TICK; GAME_OVER=1 from the next cycle.
- Legal move: seg[i] <- seg[i-1] for i=1..MAX_LEN-1; seg[0] <- next head; MOVE_TICK=1.
- DEAD: all frozen; only RESET exits.
- Query: SNAKE_HIT = OR over i<LENGTH of (seg[i]==(QUERY_X,QUERY_Y)). Active in every state, including DEAD.
- Reset values:
  - seg[i] = (START_X-i, START_Y) for all i
  - LENGTH=INIT_LEN, HEAD=(START_X,START_Y)
  - counter=0, grow_pending=0
  - SNAKE_HIT=0, MOVE_TICK=0, GAME_OVER=0
- RESET mid-move: RESET wins over the tick in the same cycle.

## Timing
- First move: TICK_DIV cycles after the cycle ENABLE is first sampled high in IDLE. Subsequent moves every TICK_DIV enabled cycles.
- HEAD_X/HEAD_Y/LENGTH update on the same edge that asserts MOVE_TICK.
- SNAKE_HIT: 1-cycle latency from QUERY_X/QUERY_Y.
- GROW and tick in the same cycle: the growth applies to that move.

## Configuration
- WRAP_EN defined: edges wrap (X GRID_W-1 -> 0 and 0 -> GRID_W-1; Y likewise with GRID_H). No wall collision.
- WRAP_EN undefined: a move leaving the grid is a collision -> DEAD, position unchanged.

## Structure
- Package snake_pkg:
  - direction encodings UP/RIGHT/DOWN/LEFT, shared with the navigation SM
  - GRID_W/GRID_H defaults and coordinate widths (8/7)
  - controller state enum
- Sub-module snake_tick_gen: TICK_DIV prescaler with enable and clear, emits one-cycle tick.

## Test plan
All scenarios use TICK_DIV=4, START=(80,60), INIT_LEN=4.
- Reset, ENABLE=1, DIRECTION=RIGHT -> first MOVE_TICK 4 cycles later; HEAD=(81,60), LENGTH=4.
- GROW pulse mid-interval, next move -> LENGTH=5; QUERY=(77,60) gives SNAKE_HIT=1 one cycle later.
- ENABLE low for 10 cycles mid-count -> no MOVE_TICK; counter resumes the remaining count.
- Drive head into its own body (grow to 5, then RIGHT, DOWN, LEFT, UP) -> DEAD, GAME_OVER=1, HEAD frozen at the last legal cell.
- Head at X=159 moving RIGHT -> WRAP_EN: HEAD_X=0; without WRAP_EN: GAME_OVER=1, HEAD_X=159.
- RESET asserted in the tick cycle -> no MOVE_TICK; all outputs at reset values next cycle.
